// File: rtl/vector_writeback_unit.sv
// vector_writeback_unit: commits 16-lane vector ops. ALU results go to the RF; stores and loads are serialized lane-by-lane.
// Latency: ALU RF write 1 cycle after accept; store strobes in cycles 1..16; load RF write in cycle 18.
// Backpressure: in_ready low during STORE/LOAD/LOAD_LAST and reset. Define VWB_FWD_EN to add fwd_* forwarding ports.
module vector_writeback_unit #(
  parameter int N  = 32,
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0][N-1:0] alu_result,
  input  logic [15:0][N-1:0] write_data,
  input  logic [3:0]         wa3,
  input  logic               reg_write,
  input  logic               memto_reg,
  input  logic               mem_write,
  output logic [AW-1:0]      mem_addr,
  output logic [N-1:0]       mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [N-1:0]       mem_rdata,
  output logic               rf_we,
  output logic [3:0]         rf_wa,
  output logic [15:0][N-1:0] rf_wd,
  output logic               busy
`ifdef VWB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [3:0]         fwd_wa,
  output logic [15:0][N-1:0] fwd_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STORE     = 3'd1,
    S_LOAD      = 3'd2,
    S_LOAD_LAST = 3'd3,
    S_WB        = 3'd4
  } state_t;

  // Scalar part of the captured operation; the vector part lives in vec_q.
  typedef struct packed {
    logic [AW-1:0] base;
    logic [3:0]    wa3;
    logic          reg_write;
  } hdr_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  hdr_t              hdr_q;
  // Holds store data, ALU result, or the load vector being assembled.
  logic [15:0][N-1:0] vec_q;

  logic              accept;
  logic [3:0]        lane_prev;
  logic [AW-1:0]     lane_addr;

  // Ready only in states that can take a new op; reset forces it low.
  assign in_ready  = !reset && ((state_q == S_IDLE) || (state_q == S_WB));
  assign accept    = in_valid && in_ready;
  // Read data returns one cycle late, so LOAD lane cnt fills lane cnt-1.
  assign lane_prev = cnt_q - 4'd1;
  // Lane address wraps modulo 2^AW by construction of the AW-bit add.
  assign lane_addr = hdr_q.base + AW'(cnt_q);

  // State and lane-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: decode at accept (from IDLE or WB), otherwise walk the lanes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_WB: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        if (accept) begin
          if (mem_write)      state_d = S_STORE;
          else if (memto_reg) state_d = S_LOAD;
          else if (reg_write) state_d = S_WB;
          else                state_d = S_IDLE;
        end
      end
      S_STORE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_LOAD_LAST;
          cnt_d   = 4'd0;
        end
      end
      S_LOAD_LAST: begin
        state_d = S_WB;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Operation capture and load-lane assembly; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q <= '0;
      vec_q <= '0;
    end else if (accept) begin
      hdr_q.base      <= alu_result[0][AW-1:0];
      hdr_q.wa3       <= wa3;
      hdr_q.reg_write <= reg_write;
      if (mem_write)       vec_q <= write_data;
      else if (!memto_reg) vec_q <= alu_result;
    end else if (state_q == S_LOAD && cnt_q != 4'd0) begin
      vec_q[lane_prev] <= mem_rdata;
    end else if (state_q == S_LOAD_LAST) begin
      vec_q[15] <= mem_rdata;
    end
  end

  // Output decode from state; anything not driven by the current state is 0.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = 4'd0;
    rf_wd     = '0;
    busy      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_STORE: begin
          mem_we    = 1'b1;
          mem_addr  = lane_addr;
          mem_wdata = vec_q[cnt_q];
          busy      = 1'b1;
        end
        S_LOAD: begin
          mem_re   = 1'b1;
          mem_addr = lane_addr;
          busy     = 1'b1;
        end
        S_LOAD_LAST: begin
          busy = 1'b1;
        end
        S_WB: begin
          rf_we = hdr_q.reg_write;
          rf_wa = hdr_q.wa3;
          rf_wd = vec_q;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

`ifdef VWB_FWD_EN
  // Forwarding mirrors the commit port so execute can bypass the RF.
  assign fwd_valid = rf_we;
  assign fwd_wa    = rf_wa;
  assign fwd_data  = rf_wd;
`endif

endmodule
